inv_key_schedule_128: RTL and testbench

- Streams AES-128 round keys in reverse order, round 10 down to round 0, for the decryption datapath.
- Loaded once with the final (round-10) round key; rolls the key schedule backwards one round per accepted transfer.
- Generates each round constant internally in descending order (0x36, 0x1b, 0x80 … 0x01), so no forward Rcon lookup and no stored key table.
- Sits between key load logic and the inverse-cipher round controller.

---
 rtl/inv_key_schedule_128_pkg.sv | 23 ++
 rtl/key_subword.sv | 32 +++
 rtl/inv_key_schedule_128.sv | 98 +++++++++
 tb/tb_inv_key_schedule_128.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_key_schedule_128_pkg.sv
// Shared AES-128 key schedule definitions: constants, state encoding and the
// small word/byte helpers used when rolling the schedule backwards.
package inv_key_schedule_128_pkg;

    localparam int          NR_128        = 10;
    localparam logic [7:0]  RCON_LAST_128 = 8'h36;
    localparam logic [7:0]  AES_POLY      = 8'h1b;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ks_state_e;

    // Inverse of xtime in GF(2^8): divides the round constant by x.
    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        return r[0] ? (((r ^ AES_POLY) >> 1) | 8'h80) : (r >> 1);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_subword.sv
// SubWord: forward AES S-box applied independently to each byte of a 32-bit word.
module key_subword (
    input  logic [31:0] word_i,
    output logic [31:0] sub_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_o[gi*8 +: 8] = SBOX[word_i[gi*8 +: 8]];
        end
    endgenerate

endmodule

// File: rtl/inv_key_schedule_128.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, it walks back
// to round 0 one key per accepted transfer, deriving Rcon on the fly.
module inv_key_schedule_128
    import inv_key_schedule_128_pkg::*;
#(
    parameter int         NR        = NR_128,
    parameter logic [7:0] RCON_LAST = RCON_LAST_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] last_key,
    output logic [127:0] key_out,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  sub_p3;
    logic [127:0] prev_key;

    assign {w0, w1, w2, w3} = key_q;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    key_subword u_subword (
        .word_i (rot_word(p3)),
        .sub_o  (sub_p3)
    );

    assign p0       = w0 ^ sub_p3 ^ {rcon_q, 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    // A load always wins, including over the final transfer, so an aborted
    // stream never reports done.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_STREAM;
            key_d   = last_key;
            round_d = 4'(NR);
            rcon_d  = RCON_LAST;
            valid_d = 1'b1;
        end else if (state_q == ST_STREAM && valid_q && key_ready) begin
            if (round_q != 4'd0) begin
                key_d   = prev_key;
                round_d = round_q - 4'd1;
                rcon_d  = inv_xtime(rcon_q);
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign key_out   = key_q;
    assign round_idx = round_q;
    assign key_valid = valid_q;
    assign busy      = (state_q == ST_STREAM);
    assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule_128.sv
// Directed bench for the reverse AES-128 key schedule using the FIPS-197
// example key expansion walked from round 10 down to round 0.
module tb_inv_key_schedule_128;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [127:0] last_key;
    logic [127:0] key_out;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    int n_pass;
    int n_total;

    logic [127:0] exp_key  [0:10];
    logic [7:0]   exp_rcon [0:10];

    inv_key_schedule_128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .last_key  (last_key),
        .key_out   (key_out),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; key_ready = 1'b0; last_key = '0;
        repeat (2) @(negedge clk);
        if ({key_out, round_idx, key_valid, busy, done, dut.rcon_q} !== '0) begin
            $display("FAIL reset_outputs: got key=%h idx=%0d v=%b busy=%b done=%b rcon=%h, want all zero",
                     key_out, round_idx, key_valid, busy, done, dut.rcon_q);
        end else n_pass++;
        n_total++;
        rst_n = 1'b1;
        @(negedge clk);
        if ({key_valid, busy, done} !== 3'b000) begin
            $display("FAIL reset_release_idle: got v=%b busy=%b done=%b, want 000", key_valid, busy, done);
        end else n_pass++;
        n_total++;
    endtask

    // Loads the FIPS-197 round-10 key and checks every key, index and Rcon
    // until the round-0 key is accepted, then checks the done pulse.
    task automatic run_stream(input bit rnd, input string tag);
        int idx;
        int cyc;
        bit fin;
        @(negedge clk);
        last_key  = exp_key[10];
        load      = 1'b1;
        key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        load = 1'b0;
        idx = 10; fin = 1'b0; cyc = 0;
        while (!fin && cyc < 400) begin
            if (key_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL %s_flags r%0d: got v=%b busy=%b done=%b, want 1 1 0", tag, idx, key_valid, busy, done);
            end else n_pass++;
            n_total++;
            if (round_idx !== 4'(idx) || key_out !== exp_key[idx]) begin
                $display("FAIL %s_key: got idx=%0d key=%h, want idx=%0d key=%h", tag, round_idx, key_out, idx, exp_key[idx]);
            end else n_pass++;
            n_total++;
            if (idx != 0) begin
                if (dut.rcon_q !== exp_rcon[idx]) begin
                    $display("FAIL %s_rcon r%0d: got %h, want %h", tag, idx, dut.rcon_q, exp_rcon[idx]);
                end else n_pass++;
                n_total++;
            end
            key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (key_ready) begin
                $display("%s: accept round %0d key %h", tag, idx, key_out);
                if (idx == 0) fin = 1'b1;
                else idx--;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) begin
            $display("FAIL %s_timeout: stuck at round %0d, want round 0 accepted", tag, idx);
            n_total++;
        end
        if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s_done: got done=%b v=%b busy=%b, want 1 0 0", tag, done, key_valid, busy);
        end else n_pass++;
        n_total++;
        key_ready = 1'b0;
        @(negedge clk);
        if (done !== 1'b0) begin
            $display("FAIL %s_done_width: got done=%b on second cycle, want 0", tag, done);
        end else n_pass++;
        n_total++;
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        key_ready = 1'b1;
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (done !== 1'b1) begin
            $display("FAIL %s_drain: got done=%b after %0d cycles, want 1", tag, done, c);
        end else n_pass++;
        n_total++;
        key_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        run_stream(1'b0, "stream");
    endtask

    task automatic test_backpressure();
        run_stream(1'b1, "bp");
    endtask

    task automatic test_abort();
        @(negedge clk);
        last_key = exp_key[10]; load = 1'b1; key_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        if (round_idx !== 4'd6 || key_out !== exp_key[6]) begin
            $display("FAIL abort_pre: got idx=%0d key=%h, want idx=6 key=%h", round_idx, key_out, exp_key[6]);
        end else n_pass++;
        n_total++;
        last_key = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (round_idx !== 4'd10 || key_out !== 128'h0 || key_valid !== 1'b1 || done !== 1'b0) begin
            $display("FAIL abort_restart: got idx=%0d key=%h v=%b done=%b, want idx=10 key=0 v=1 done=0",
                     round_idx, key_out, key_valid, done);
        end else n_pass++;
        n_total++;
        @(negedge clk);
        if (round_idx !== 4'd9 || key_out !== 128'h55636363_00000000_00000000_00000000 ||
            dut.rcon_q !== 8'h1b || done !== 1'b0) begin
            $display("FAIL abort_zero_r9: got idx=%0d key=%h rcon=%h done=%b, want idx=9 key=55636363000000000000000000000000 rcon=1b done=0",
                     round_idx, key_out, dut.rcon_q, done);
        end else n_pass++;
        n_total++;
        drain("abort");
    endtask

    task automatic test_midstream_reset();
        int c;
        @(negedge clk);
        last_key = exp_key[10]; load = 1'b1; key_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        c = 0;
        while (round_idx !== 4'd5 && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (round_idx !== 4'd5) begin
            $display("FAIL rst_reach5: got idx=%0d, want 5", round_idx);
        end else n_pass++;
        n_total++;
        rst_n = 1'b0;
        #1;
        if ({key_out, round_idx, key_valid, busy, done, dut.rcon_q} !== '0) begin
            $display("FAIL rst_async: got key=%h idx=%0d v=%b busy=%b done=%b rcon=%h, want all zero",
                     key_out, round_idx, key_valid, busy, done, dut.rcon_q);
        end else n_pass++;
        n_total++;
        key_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(1'b0, "post_rst");
    endtask

    task automatic test_load_on_final();
        int c;
        @(negedge clk);
        last_key = exp_key[10]; load = 1'b1; key_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        c = 0;
        while (round_idx !== 4'd0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (round_idx !== 4'd0 || key_out !== exp_key[0]) begin
            $display("FAIL final_reach0: got idx=%0d key=%h, want idx=0 key=%h", round_idx, key_out, exp_key[0]);
        end else n_pass++;
        n_total++;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (done !== 1'b0 || key_valid !== 1'b1 || round_idx !== 4'd10 || key_out !== exp_key[10]) begin
            $display("FAIL final_restart: got done=%b v=%b idx=%0d key=%h, want done=0 v=1 idx=10 key=%h",
                     done, key_valid, round_idx, key_out, exp_key[10]);
        end else n_pass++;
        n_total++;
        @(negedge clk);
        if (done !== 1'b0 || round_idx !== 4'd9 || key_out !== exp_key[9]) begin
            $display("FAIL final_next: got done=%b idx=%0d key=%h, want done=0 idx=9 key=%h",
                     done, round_idx, key_out, exp_key[9]);
        end else n_pass++;
        n_total++;
        drain("final");
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_rcon[0]  = 8'h00;
        exp_rcon[1]  = 8'h01;
        exp_rcon[2]  = 8'h02;
        exp_rcon[3]  = 8'h04;
        exp_rcon[4]  = 8'h08;
        exp_rcon[5]  = 8'h10;
        exp_rcon[6]  = 8'h20;
        exp_rcon[7]  = 8'h40;
        exp_rcon[8]  = 8'h80;
        exp_rcon[9]  = 8'h1b;
        exp_rcon[10] = 8'h36;

        test_reset();
        test_stream();
        test_backpressure();
        test_abort();
        test_midstream_reset();
        test_load_on_final();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
